// File: rtl/ir_cmd_handler_if.sv
// Decoder-to-handler frame handshake.
//   cmd_ready : decoder frame-complete flag (asynchronous to the handler clock)
//   command   : 32-bit NEC frame, stable while cmd_ready is high
//   ack       : handler has consumed the frame; held until cmd_ready is seen low
interface ir_cmd_handler_if;
  logic        cmd_ready;
  logic [31:0] command;
  logic        ack;

  modport master (output cmd_ready, output command, input  ack);
  modport slave  (input  cmd_ready, input  command, output ack);
endinterface

// File: rtl/ir_cmd_handler.sv
// NEC frame consumer: captures decoder frames under a ready/ack handshake,
// validates the complement bytes, optionally filters on device address and
// queues {address, command} key events in a first-word-fall-through FIFO.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   dec            : frame handshake (cmd_ready, command, ack)
//   key_pop        : consumer removes the FIFO head
//   key_avail      : FIFO not empty
//   key_code/addr  : command/address byte at the FIFO head (0 when empty)
//   fifo_full      : FIFO holds FIFO_DEPTH entries
//   fifo_level     : FIFO occupancy
//   err_count      : complement-check failures, saturating
//   drop_count     : valid frames lost to a full FIFO, saturating
//   ack_timeout    : sticky ack-timeout flag
module ir_cmd_handler #(
  parameter bit          ADDR_FILTER_EN = 1'b0,
  parameter logic [7:0]  ADDR_MATCH     = 8'h00,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ACK_TIMEOUT    = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  ir_cmd_handler_if.slave             dec,
  input  logic                        key_pop,
  output logic                        key_avail,
  output logic [7:0]                  key_code,
  output logic [7:0]                  key_addr,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  err_count,
  output logic [7:0]                  drop_count,
  output logic                        ack_timeout
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, CHECK, ACK, WAIT_LOW} state_t;

  state_t         state_q, state_d;
  logic           sync1_q, ready_s_q;
  logic [31:0]    cap_q, cap_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           ack_timeout_q, ack_timeout_d;
  logic [7:0]     err_q, err_d, drop_q, drop_d;
  logic [15:0]    mem_q [FIFO_DEPTH];
  logic [15:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;

  logic fmt_ok, addr_ok, full, empty, push, pop;

  assign fmt_ok  = (cap_q[15:8] == ~cap_q[7:0]) && (cap_q[31:24] == ~cap_q[23:16]);
  assign addr_ok = !ADDR_FILTER_EN || (cap_q[7:0] == ADDR_MATCH);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  // Full test uses the pre-pop level: a push into a full FIFO is dropped
  // even if the consumer pops in the same cycle.
  assign push    = (state_q == CHECK) && fmt_ok && addr_ok && !full;
  assign pop     = key_pop && !empty;

  always_comb begin
    state_d       = state_q;
    cap_d         = cap_q;
    timer_d       = timer_q;
    ack_timeout_d = ack_timeout_q;
    err_d         = err_q;
    drop_d        = drop_q;
    unique case (state_q)
      IDLE: begin
        if (ready_s_q) begin
          cap_d   = dec.command;
          state_d = CHECK;
        end
      end
      CHECK: begin
        timer_d = '0;
        if (!fmt_ok) begin
          if (err_q != '1) err_d = err_q + 8'd1;
        end else if (addr_ok && full) begin
          if (drop_q != '1) drop_d = drop_q + 8'd1;
        end
        state_d = ACK;
      end
      ACK: begin
        if (!ready_s_q) begin
          state_d = IDLE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_timeout_d = 1'b1;
          state_d       = WAIT_LOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!ready_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cap_q[7:0], cap_q[23:16]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      ready_s_q     <= 1'b0;
      state_q       <= IDLE;
      cap_q         <= '0;
      timer_q       <= '0;
      ack_timeout_q <= 1'b0;
      err_q         <= '0;
      drop_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q       <= dec.cmd_ready;
      ready_s_q     <= sync1_q;
      state_q       <= state_d;
      cap_q         <= cap_d;
      timer_q       <= timer_d;
      ack_timeout_q <= ack_timeout_d;
      err_q         <= err_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      mem_q         <= mem_d;
    end
  end

  assign dec.ack     = (state_q == ACK);
  assign key_avail   = !empty;
  // Head bytes are forced to zero when empty so reset shows key_code/key_addr = 0.
  assign key_addr    = empty ? '0 : mem_q[rd_ptr_q][15:8];
  assign key_code    = empty ? '0 : mem_q[rd_ptr_q][7:0];
  assign fifo_full   = full;
  assign fifo_level  = level_q;
  assign err_count   = err_q;
  assign drop_count  = drop_q;
  assign ack_timeout = ack_timeout_q;

endmodule

// File: doc/ir_cmd_handler.md
# ir_cmd_handler

Downstream consumer of the IR remote decoder's 32-bit NEC frame output. Each frame is captured under a ready/ack handshake. The block then checks the address/command complement fields, optionally filters on device address, and queues valid key events in a small FIFO. A consumer such as an LED/7-segment driver or a CPU register interface pops key events from that FIFO.

## Interface
- ADDR_FILTER_EN, 0: when 1, frames whose address byte differs from ADDR_MATCH are discarded silently.
- ADDR_MATCH, 8'h00: accepted device address when filtering is enabled.
- FIFO_DEPTH, 4: key FIFO entries; must be a power of 2, at least 2.
- ACK_TIMEOUT, 4096: maximum clk cycles ack is held while waiting for cmd_ready to fall.

Ports:
- clk, in, 1: system clock, the same clock the decoder divides down.
- rst, in, 1: asynchronous reset, active-high.
- cmd_ready, in, 1: decoder frame-complete flag; asynchronous to clk.
- command, in, 32: decoder frame. [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command. Stable while cmd_ready is high.
- ack, out, 1: frame consumed; held high until cmd_ready is seen low.
- key_pop, in, 1: consumer removes the FIFO head.
- key_avail, out, 1: FIFO not empty.
- key_code, out, 8: command byte at the FIFO head.
- key_addr, out, 8: address byte at the FIFO head.
- fifo_full, out, 1: FIFO holds FIFO_DEPTH entries.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- err_count, out, 8: complement-check failures; saturates at 255.
- drop_count, out, 8: valid frames lost because the FIFO was full; saturates at 255.
- ack_timeout, out, 1: sticky; set on an ack timeout, cleared only by rst.

## Operation
- cmd_ready passes through a 2-flop synchronizer (ready_s, reset 0). command is sampled only in IDLE after ready_s is 1, so it needs no synchronizer.
- FSM states are IDLE, CHECK, ACK and WAIT_LOW; reset state is IDLE.
- IDLE: if ready_s=1, latch command into cap and go to CHECK.
- CHECK (single cycle): fmt_ok is true when cap[15:8]==~cap[7:0] and cap[31:24]==~cap[23:16].
  - fmt_ok=0: increment err_count.
  - fmt_ok=1 and address filtered out: no action.
  - Otherwise, FIFO full: increment drop_count.
  - Otherwise: push {cap[7:0], cap[23:16]}.
  - Always go to ACK next.
- ACK: ack=1 and an ack timer runs.
  - If ready_s=0: go to IDLE.
  - Else if the timer reaches ACK_TIMEOUT-1: set ack_timeout and go to WAIT_LOW.
- WAIT_LOW: ack=0. Go to IDLE when ready_s=0. This guarantees no frame is recaptured while cmd_ready is still high.
- FIFO is first-word-fall-through. key_code and key_addr show the head entry whenever key_avail=1; their values are don't-care when empty.
- key_pop with key_avail=1 removes the head. key_pop while empty is ignored.
- Push and pop in the same cycle: both occur and the level is unchanged.
  - The full check uses the level before the pop, so a push into a full FIFO is dropped even when a pop happens in the same cycle.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full and empty are derived from fifo_level.
- Reset values:
  - ack=0, key_avail=0, fifo_full=0, fifo_level=0, err_count=0, drop_count=0, ack_timeout=0.
  - key_code=0 and key_addr=0.
- Reset mid-operation returns to IDLE and empties the FIFO. If cmd_ready is still high after reset, that frame is captured again; this is by design.

## Timing
- cmd_ready rises before edge 0. ready_s=1 after edge 1.
- Edge 2: IDLE→CHECK, command captured.
- Edge 3: CHECK→ACK, push performed. ack=1 and key_avail=1 (for an empty FIFO) are both visible after edge 3.
- ack falls on the edge after ready_s is seen low. That is the third edge after cmd_ready falls.
- key_avail deasserts on the edge that pops the last entry.
- Counter updates are visible one cycle after the CHECK edge.
- Timeout: ack is high for exactly ACK_TIMEOUT cycles. It falls, and ack_timeout rises, on the same edge.
- Minimum frame-to-frame spacing is 6 clk cycles; the decoder's frame period is far longer.

## Test plan
- Valid frame: command=32'hBF40FD02, pulse cmd_ready ~100 cycles, then release.
  - Expect ack high from edge 3 until 3 edges after cmd_ready falls.
  - Expect key_avail=1, key_addr=8'h02, key_code=8'h40, fifo_level=1.
  - key_pop → key_avail=0.
- Bad complement: command=32'hBF40FC02.
  - Expect err_count=1, FIFO empty, ack handshake still completed.
- Overflow: five valid frames with key_code 1..5 and no pops.
  - Expect fifo_full=1, drop_count=1.
  - Popping in order returns 1, 2, 3, 4.
  - Simultaneous push and pop at level 2 keeps the level at 2.
- Ack timeout: cmd_ready held high for 6000 cycles.
  - Expect ack high for 4096 cycles, then ack_timeout=1 and ack=0.
  - Only one FIFO entry.
  - A new cmd_ready pulse after release is accepted.
- Address filter: ADDR_FILTER_EN=1, ADDR_MATCH=8'h02.
  - 32'hBF40EF10 → no push, err_count=0, ack completed.
  - 32'hBF40FD02 → pushed.
- Reset mid-ACK with the FIFO at level 3.
  - All outputs return to their reset values.
  - With cmd_ready still high, the frame is recaptured and fifo_level=1.
